// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: operation codes, sequencer
// states and the iteration-counter width helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } mdu_state_e;

  localparam int unsigned MDU_WIDTH = 32;

  // Counter must hold 0..WIDTH, hence one bit more than log2.
  function automatic int unsigned mdu_cnt_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  localparam int unsigned MDU_CNT_W = mdu_cnt_w(MDU_WIDTH);

endpackage

// File: rtl/mdu_iter.sv
// One radix-2 step on the {acc, shreg} pair: shift-add for multiply
// (shreg holds the multiplier, product shifts in from the top) or
// restoring subtract for divide (shreg holds the dividend, quotient
// bits shift in from the bottom). Purely combinational.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] shreg_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] shreg_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Select between the multiply and divide step.
  always_comb begin
    sum    = {1'b0, acc_i} + (shreg_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    rem_sh = {acc_i, shreg_i[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd_i};
    if (is_div) begin
      // diff[WIDTH] is the borrow: set when the partial remainder is smaller.
      if (!diff[WIDTH]) begin
        acc_o   = diff[WIDTH-1:0];
        shreg_o = {shreg_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o   = rem_sh[WIDTH-1:0];
        shreg_o = {shreg_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o   = sum[WIDTH:1];
      shreg_o = {sum[0], shreg_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide sequencer owning HI/LO.
// Optional macro MDU_EARLY_OUT_EN: multiply leaves CALC once the remaining
// multiplier bits are zero; results are identical, only latency changes.
// Handshake: start is sampled only in IDLE; busy is high while an operation
// is in flight (start is ignored then, nothing is queued); done pulses for
// one cycle in the same cycle the new HI/LO become visible and busy drops.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int unsigned CW = mdu_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             op_div, op_signed, is_muldiv;
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] it_acc, it_shreg;
  logic [2*WIDTH-1:0] aligned;
  logic             early_exit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  // Operand decode: magnitudes for signed ops plus the sign flags.
  always_comb begin
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    is_muldiv = (op == OP_MULT) || (op == OP_MULTU) || op_div;
    a_neg     = op_signed && srca[WIDTH-1];
    b_neg     = op_signed && srcb[WIDTH-1];
    b_zero    = (srcb == '0);
    a_abs     = a_neg ? -srca : srca;
    b_abs     = b_neg ? -srcb : srcb;
  end

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div  (is_div_q),
    .acc_i   (acc_q),
    .shreg_i (shreg_q),
    .opnd_i  (opnd_q),
    .acc_o   (it_acc),
    .shreg_o (it_shreg)
  );

`ifdef MDU_EARLY_OUT_EN
  logic [WIDTH-1:0] rem_mask;
  logic [CW-1:0]    shamt;
  // Early exit: low (WIDTH-1-cnt) bits of shreg still hold unprocessed
  // multiplier bits; once they are zero the product only needs aligning.
  always_comb begin
    rem_mask   = {WIDTH{1'b1}} >> (cnt_q + 1'b1);
    shamt      = LAST_CNT - cnt_q;
    early_exit = !is_div_q && ((it_shreg & rem_mask) == '0);
    aligned    = {it_acc, it_shreg} >> shamt;
  end
`else
  // Fixed-length iteration: the product is already aligned at the last step.
  always_comb begin
    early_exit = 1'b0;
    aligned    = {it_acc, it_shreg};
  end
`endif

  // Sign fix applied in SIGN: product/quotient by neg_lo, remainder by neg_hi.
  always_comb begin
    prod_fix = neg_lo_q ? -{acc_q, shreg_q} : {acc_q, shreg_q};
    q_fix    = neg_lo_q ? -shreg_q : shreg_q;
    r_fix    = neg_hi_q ? -acc_q : acc_q;
  end

  // Sequencer next-state, datapath loads and HI/LO writes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    shreg_d  = shreg_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // cancel in the same cycle drops the start.
        if (start && !cancel) begin
          if (is_muldiv) begin
            state_d  = CALC;
            cnt_d    = '0;
            acc_d    = '0;
            shreg_d  = op_div ? a_abs : b_abs;
            opnd_d   = op_div ? b_abs : a_abs;
            is_div_d = op_div;
            // Divide by zero keeps the all-ones quotient unsigned.
            neg_lo_d = (a_neg ^ b_neg) && !(op_div && b_zero);
            neg_hi_d = op_div && a_neg;
          end else if (op == OP_MTHI) begin
            hi_d = srca;
          end else if (op == OP_MTLO) begin
            lo_d = srca;
          end
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          acc_d   = it_acc;
          shreg_d = it_shreg;
          cnt_d   = cnt_q + 1'b1;
          if ((cnt_q == LAST_CNT) || early_exit) begin
            state_d = SIGN;
            acc_d   = aligned[2*WIDTH-1:WIDTH];
            shreg_d = aligned[WIDTH-1:0];
          end
        end
      end
      SIGN: begin
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d = q_fix;
            hi_d = r_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      shreg_q  <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      shreg_q  <= shreg_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: reset, MTHI/MTLO, signed/unsigned multiply
// and divide vectors, divide by zero, ignored starts, cancel and reset abort.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srca, srcb;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] prev_hi, prev_lo;

  mdu_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .srca      (srca),
    .srcb      (srcb),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected cycles from start acceptance to done.
  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] b);
    int lat;
    lat = 34;
`ifdef MDU_EARLY_OUT_EN
    if (o == OP_MULT || o == OP_MULTU) begin
      logic [31:0] m;
      m = (o == OP_MULT && b[31]) ? -b : b;
      lat = 3;
      for (int i = 0; i < 32; i++)
        if (m[i]) lat = i + 3;
    end
`endif
    return lat;
  endfunction

  // Issue one mul/div and follow it cycle by cycle to done.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int lat;
    lat = exp_lat(o, b);
    start = 1'b1; op = o; srca = a; srcb = b;
    tick();
    start = 1'b0; op = OP_NOP;
    for (int n = 1; n <= lat; n++) begin
      if (n > 1) tick();
      check({tag, " busy"}, {31'd0, busy}, {31'd0, (n < lat)});
      check({tag, " done"}, {31'd0, done}, {31'd0, (n == lat)});
      if (n == 1)       check({tag, " state calc"}, {30'd0, dbg_state}, {30'd0, CALC});
      if (n == lat - 1) check({tag, " state sign"}, {30'd0, dbg_state}, {30'd0, SIGN});
      if (n < lat) begin
        check({tag, " hi hold"}, hi, prev_hi);
        check({tag, " lo hold"}, lo, prev_lo);
      end
    end
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    tick();
    check({tag, " done drop"}, {31'd0, done}, 32'd0);
    prev_hi = eh;
    prev_lo = el;
  endtask

  // Single-cycle MTHI/MTLO or ignored start.
  task automatic run_move(input string tag, input logic [2:0] o, input logic [31:0] a);
    start = 1'b1; op = o; srca = a; srcb = 32'h0;
    tick();
    start = 1'b0; op = OP_NOP;
    if (o == OP_MTHI) prev_hi = a;
    if (o == OP_MTLO) prev_lo = a;
    check({tag, " hi"}, hi, prev_hi);
    check({tag, " lo"}, lo, prev_lo);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    check({tag, " done"}, {31'd0, done}, 32'd0);
    tick();
    check({tag, " busy2"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = OP_NOP; srca = '0; srcb = '0; cancel = 1'b0;
    prev_hi = 32'h0; prev_lo = 32'h0;
    tick(); tick();
    reset = 1'b0;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset state", {30'd0, dbg_state}, {30'd0, IDLE});

    run_move("mthi", OP_MTHI, 32'h1234_5678);

    run_op("multu max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult neg",   OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu 5x3",  OP_MULTU, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 32'h0000_000F);
    run_op("mult zero",  OP_MULT,  32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    run_op("div neg",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("div negb",   OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu",       OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E);
    run_op("divu by0",   OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF);
    run_op("div by0",    OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    run_move("nop start", OP_NOP, 32'hDEAD_BEEF);
    run_move("op7 start", 3'd7,   32'hDEAD_BEEF);

    // start together with cancel in IDLE is dropped
    start = 1'b1; op = OP_MULTU; srca = 32'h3; srcb = 32'h3; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("start+cancel busy", {31'd0, busy}, 32'd0);
    check("start+cancel hi", hi, prev_hi);

    // cancel mid-operation, with an ignored start while busy
    run_move("mthi 11", OP_MTHI, 32'h0000_0011);
    run_move("mtlo 22", OP_MTLO, 32'h0000_0022);
    start = 1'b1; op = OP_MULTU; srca = 32'hFFFF_FFFF; srcb = 32'hFFFF_FFFF;
    tick();
    start = 1'b0; op = OP_NOP;
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) tick();
      check("cancel busy", {31'd0, busy}, {31'd0, (i <= 10)});
      check("cancel done", {31'd0, done}, 32'd0);
      if (i == 5)  begin start = 1'b1; op = OP_DIVU; srca = 32'h9; srcb = 32'h3; end
      if (i == 6)  begin start = 1'b0; op = OP_NOP; end
      if (i == 10) cancel = 1'b1;
      if (i == 11) cancel = 1'b0;
    end
    check("cancel hi", hi, 32'h0000_0011);
    check("cancel lo", lo, 32'h0000_0022);

    // reset aborts an in-flight operation
    start = 1'b1; op = OP_MULTU; srca = 32'h7; srcb = 32'h9;
    tick();
    start = 1'b0; op = OP_NOP;
    for (int i = 2; i <= 5; i++) tick();
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    prev_hi = 32'h0; prev_lo = 32'h0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h0);

    run_op("post reset", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Iterative multiply/divide unit and sequencer for the multi-cycle MIPS core; owns the HI/LO registers.
- Services MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Main controller issues `start` with operands from the A/B registers, then stalls on `busy` before issuing MFHI/MFLO.
- Computes one bit per cycle (shift-add multiply, restoring divide) with a final sign-fix cycle.

Parameters:
- WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  issue request; sampled only in IDLE.
- op  in  3  mdu_op_e: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
- srca  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
- srcb  in  WIDTH  rt operand (multiplier / divisor).
- cancel  in  1  exception abort; discards any in-flight operation.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO are updated by a mul/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0; all internal shift registers cleared. Reset mid-operation aborts it the same way.
- States: IDLE, CALC, SIGN.
  - IDLE -> CALC on start with op in {MULT, MULTU, DIV, DIVU}.
  - CALC -> SIGN after WIDTH iterations.
  - SIGN -> IDLE.
- Start accepted at cycle T:
  - Operands latched: absolute values for signed ops; negate flags recorded.
  - CALC occupies T+1..T+WIDTH, with the iteration counter running 0..WIDTH-1. SIGN occupies T+WIDTH+1.
  - busy=1 for T+1..T+WIDTH+1.
  - hi/lo written at the end of SIGN, so they are visible and done=1 at T+WIDTH+2 (T+34 for WIDTH=32). busy=0 in the same cycle.
- Multiply: 2*WIDTH-bit product; hi=upper half, lo=lower half. MULT negates the product iff operand signs differ.
- Divide: lo=quotient, hi=remainder.
  - DIV negates the quotient iff signs differ; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (no trap).
- Divide by zero (srcb==0): the full sequence still runs; result is hi=srca (unchanged, unsigned), lo=all-ones. Latency is the same.
- MTHI/MTLO with start in IDLE: hi (or lo) = srca on the next edge; the other register is unchanged. busy and done stay 0.
- NOP, or an undefined op 7, with start: ignored.
- start while busy: ignored; no queueing.
- cancel in CALC/SIGN: state -> IDLE next edge, hi/lo unchanged, no done. cancel in IDLE has no effect. cancel together with start in IDLE: the start is dropped.
- Simultaneous reset and anything: reset wins.
- hi/lo are never partially updated; intermediate accumulators are internal.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined:
  - Multiply leaves CALC as soon as the remaining (shifted) multiplier bits are all zero, after at least one iteration. The accumulator is aligned to the full product before SIGN.
  - Multiply latency = (index of highest set multiplier magnitude bit + 1) + 2 cycles. A multiplier of 0 exits after 1 iteration.
  - Divide is unaffected.
- Not defined: fixed WIDTH iterations for all ops.
- Results are identical either way.

Decomposition:
- Package mdu_pkg holds:
  - mdu_op_e (3-bit enum, values above);
  - mdu_state_e {IDLE, CALC, SIGN};
  - the localparam for counter width, $clog2(WIDTH)+1.
- Sub-module mdu_iter (combinational): one shift-add or restoring-subtract step on {acc, shreg} selected by an is_div input. mdu_ctrl holds the FSM, counter, sign flags and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, start at T -> hi=0xFFFFFFFE, lo=0x00000001, done pulse only at T+34, busy T+1..T+33.
- MULT srca=0xFFFFFFFD (-3), srcb=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV srca=0xFFFFFFF9 (-7), srcb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU srca=0x64, srcb=0 -> hi=0x64, lo=0xFFFFFFFF at T+34.
- Prior hi/lo=0x11/0x22. MULTU start, second start at T+5 (ignored), cancel at T+10 -> busy=0 at T+11, no done, hi/lo still 0x11/0x22. Reset at T+5 of a fresh op -> hi/lo=0, busy=0.
- MTHI srca=0x12345678 -> hi=0x12345678 next cycle, lo unchanged, busy/done never high. With MDU_EARLY_OUT_EN, MULTU 5*3 -> done at T+4, lo=15.
